// File: rtl/ext_link_peer.sv
// Far-end controller for the baud-calibrated single-pair link. Half-duplex:
// receives (measures the calibration pulse, acks, samples 10 bits, final ack)
// or sends (calibration pulse, waits for acks, drives start + 10 bits MSB first).
`timescale 1ns/1ps
module ext_link_peer #(
  parameter logic [15:0] BAUD_SIZE   = 16'd8,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd64,
  parameter logic [3:0]  ACK_GAP     = 4'd2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic       tx,
  input  logic       s_valid,
  input  logic [9:0] s_data,
  output logic       s_ready,
  output logic       m_valid,
  output logic [9:0] m_data,
  output logic       send_done,
  output logic       err,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StRxCal   = 4'd1,
    StRxWait  = 4'd2,
    StRxAck   = 4'd3,
    StRxStart = 4'd4,
    StRxHalf  = 4'd5,
    StRxBits  = 4'd6,
    StRxGap   = 4'd7,
    StRxFack  = 4'd8,
    StTxCal   = 4'd9,
    StTxAckl  = 4'd10,
    StTxAckh  = 4'd11,
    StTxGap   = 4'd12,
    StTxBits  = 4'd13,
    StTxFackl = 4'd14,
    StTxFackh = 4'd15
  } state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rs_q;
  logic [15:0] len_q, len_d;     // bit length L
  logic [15:0] cnt_q, cnt_d;     // cycle position within the current baud, 1..L
  logic [7:0]  nb_q, nb_d;       // bit index / baud count within a state
  logic [9:0]  sh_q, sh_d;       // shared rx/tx shift register
  logic [9:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        send_done_q, send_done_d;
  logic        err_q, err_d;
  logic        tx_q, tx_d;

  logic        baud_end;
  logic [15:0] cnt_inc;
  logic        ack_timeout;

  assign baud_end    = (cnt_q == len_q);
  assign cnt_inc     = cnt_q + 16'd1;
  assign ack_timeout = baud_end && (nb_q == ACK_TIMEOUT - 8'd1);

  // Two-flop rx synchronizer, idle-high reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rs_q      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rs_q      <= rx_meta_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      len_q       <= 16'd0;
      cnt_q       <= 16'd0;
      nb_q        <= 8'd0;
      sh_q        <= 10'd0;
      m_data_q    <= 10'd0;
      m_valid_q   <= 1'b0;
      send_done_q <= 1'b0;
      err_q       <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      nb_q        <= nb_d;
      sh_q        <= sh_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      send_done_q <= send_done_d;
      err_q       <= err_d;
      tx_q        <= tx_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    nb_d        = nb_q;
    sh_d        = sh_q;
    m_data_d    = m_data_q;
    m_valid_d   = 1'b0;
    send_done_d = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A falling line beats a pending send.
        if (!rs_q) begin
          state_d = StRxCal;
          len_d   = 16'd1;
        end else if (s_valid) begin
          state_d = StTxCal;
          len_d   = BAUD_SIZE;
          sh_d    = s_data;
          cnt_d   = 16'd1;
        end
      end
      StRxCal: begin
        if (!rs_q) begin
          if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
        end else if (len_q < 16'd2) begin
          state_d = StIdle;
        end else begin
          // The rising-edge cycle counts as the first wait cycle.
          state_d = StRxWait;
          cnt_d   = 16'd2;
        end
      end
      StRxWait: begin
        if (baud_end) begin
          state_d = StRxAck;
          cnt_d   = 16'd1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRxAck: begin
        if (baud_end) state_d = StRxStart;
        else          cnt_d   = cnt_inc;
      end
      StRxStart: begin
        if (!rs_q) begin
          state_d = StRxHalf;
          cnt_d   = 16'd1;
        end
      end
      StRxHalf: begin
        if (cnt_q == {1'b0, len_q[15:1]}) begin
          if (rs_q) begin
            state_d = StRxStart;
          end else begin
            state_d = StRxBits;
            cnt_d   = 16'd1;
            nb_d    = 8'd0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRxBits: begin
        if (baud_end) begin
          sh_d  = {sh_q[8:0], rs_q};
          cnt_d = 16'd1;
          if (nb_q == 8'd9) begin
            // The last sample cycle counts as the first gap cycle.
            state_d = StRxGap;
            cnt_d   = 16'd2;
            nb_d    = 8'd0;
          end else begin
            nb_d = nb_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRxGap: begin
        if (baud_end) begin
          cnt_d = 16'd1;
          if (nb_q == {4'd0, ACK_GAP} - 8'd1) state_d = StRxFack;
          else                                nb_d    = nb_q + 8'd1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRxFack: begin
        if (baud_end) begin
          state_d   = StIdle;
          m_valid_d = 1'b1;
          m_data_d  = sh_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StTxCal: begin
        if (baud_end) begin
          state_d = StTxAckl;
          cnt_d   = 16'd1;
          nb_d    = 8'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StTxAckl, StTxFackl: begin
        if (!rs_q) begin
          state_d = (state_q == StTxAckl) ? StTxAckh : StTxFackh;
        end else if (ack_timeout) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (baud_end) begin
          cnt_d = 16'd1;
          nb_d  = nb_q + 8'd1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StTxAckh: begin
        if (rs_q) begin
          state_d = StTxGap;
          cnt_d   = 16'd1;
        end
      end
      StTxGap: begin
        if (baud_end) begin
          state_d = StTxBits;
          cnt_d   = 16'd1;
          nb_d    = 8'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StTxBits: begin
        // nb 0 is the start bit, 1..10 are data bits 9..0.
        if (baud_end) begin
          cnt_d = 16'd1;
          if (nb_q == 8'd10) begin
            state_d = StTxFackl;
            nb_d    = 8'd0;
          end else begin
            nb_d = nb_q + 8'd1;
            if (nb_q != 8'd0) sh_d = {sh_q[8:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StTxFackh: begin
        if (rs_q) begin
          state_d     = StIdle;
          send_done_d = 1'b1;
        end
      end
    endcase
  end

  // Registered tx line, decoded from next-cycle state so it tracks state_q exactly.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StRxAck, StRxFack, StTxCal: tx_d = 1'b0;
      StTxBits:                   tx_d = (nb_d == 8'd0) ? 1'b0 : sh_d[9];
      default:                    tx_d = 1'b1;
    endcase
  end

  assign tx        = tx_q;
  assign s_ready   = rstn && (state_q == StIdle) && rs_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign send_done = send_done_q;
  assign err       = err_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_ext_link_peer.sv
// Directed bench for ext_link_peer: stimulus and expected outputs are laid out
// per cycle from the link timing rules, then compared every cycle.
`timescale 1ns/1ps
module tb_ext_link_peer;

  localparam int NCYC    = 1300;
  localparam int SYNC    = 2;
  localparam int ACKGAP  = 2;
  localparam int TIMEOUT = 64;
  localparam int L8      = 8;

  logic       clk = 1'b0;
  logic       rstn, rx, tx, s_valid, s_ready, m_valid, send_done, err;
  logic [9:0] s_data, m_data;
  logic [3:0] state_out;

  ext_link_peer #(
    .BAUD_SIZE  (16'd8),
    .ACK_TIMEOUT(8'd64),
    .ACK_GAP    (4'd2)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx       (rx),
    .tx       (tx),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .send_done(send_done),
    .err      (err),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Stimulus schedule
  bit         rx_s  [NCYC];
  bit         rst_s [NCYC];
  bit         sv_s  [NCYC];
  logic [9:0] sd_s  [NCYC];
  // Expected outputs
  bit         exp_tx  [NCYC];
  bit         exp_mv  [NCYC];
  bit         exp_sd  [NCYC];
  bit         exp_err [NCYC];
  logic [9:0] exp_md  [NCYC];

  typedef struct { int c; int sel; int v; } lit_t;
  lit_t lits[$];

  int         cyc = 0;
  bit         running = 1'b0;
  int         checks = 0;
  int         failures = 0;
  logic [9:0] cur_md = 10'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  // sel: 0 state_out, 1 s_ready, 2 tx, 3 m_valid, 4 send_done, 5 err
  task automatic lit(input int c, input int sel, input int v);
    lit_t e;
    e.c = c; e.sel = sel; e.v = v;
    lits.push_back(e);
  endtask

  task automatic drive_low(input int from, input int len);
    for (int i = 0; i < len; i++) rx_s[from + i] = 1'b0;
  endtask

  task automatic drive_word(input int b, input int l, input logic [9:0] w);
    drive_low(b, l);
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < l; j++) rx_s[b + (k + 1) * l + j] = w[9 - k];
  endtask

  task automatic expect_low(input int from, input int len);
    for (int i = 0; i < len; i++) exp_tx[from + i] = 1'b0;
  endtask

  // Receive: cal pulse on rx at cal (width l), start bit on rx at st.
  task automatic model_rx(input int cal, input int l, input int st, input logic [9:0] w);
    int r, f, s9;
    r  = cal + SYNC + l;
    f  = st + SYNC;
    s9 = f + l / 2 + 10 * l;
    expect_low(r + l, l);
    expect_low(s9 + ACKGAP * l, l);
    exp_mv[s9 + (ACKGAP + 1) * l] = 1'b1;
    exp_md[s9 + (ACKGAP + 1) * l] = w;
  endtask

  // Send accepted at a; far end acks (width l) on rx at ack and fack (fack<0: none).
  task automatic model_tx(input int a, input int l, input logic [9:0] w, input int ack,
                          input int fack);
    int g;
    expect_low(a + 1, l);
    g = ack + SYNC + l + 1 + l;
    expect_low(g, l);
    for (int k = 0; k < 10; k++) if (!w[9 - k]) expect_low(g + (k + 1) * l, l);
    if (fack >= 0) exp_sd[fack + SYNC + l + 1] = 1'b1;
  endtask

  task automatic model_timeout(input int a, input int l);
    expect_low(a + 1, l);
    exp_err[a + 1 + l + TIMEOUT * l] = 1'b1;
  endtask

  task automatic build();
    int a, ack, fack;
    for (int k = 0; k < NCYC; k++) begin
      rx_s[k] = 1'b1; rst_s[k] = 1'b1; sv_s[k] = 1'b0; sd_s[k] = 10'd0;
      exp_tx[k] = 1'b1; exp_mv[k] = 1'b0; exp_sd[k] = 1'b0; exp_err[k] = 1'b0;
      exp_md[k] = 10'd0;
    end
    for (int k = 0; k < 4; k++) rst_s[k] = 1'b0;
    lit(2, 1, 0); lit(2, 0, 0); lit(4, 1, 1);

    // Receive 0x0A5 at L=8
    drive_low(10, L8);
    drive_word(40, L8, 10'h0A5);
    model_rx(10, L8, 40, 10'h0A5);
    lit(27, 2, 1); lit(28, 2, 0); lit(35, 2, 0); lit(36, 2, 1); lit(30, 0, 3);
    lit(100, 0, 6); lit(130, 0, 7); lit(141, 2, 1); lit(142, 2, 0); lit(150, 3, 1);

    // One-cycle glitch
    drive_low(160, 1);
    lit(163, 0, 1); lit(164, 0, 0);

    // Odd L=7, a 2-cycle false start, then word 0x3C7
    drive_low(170, 7);
    drive_low(200, 2);
    drive_word(210, 7, 10'h3C7);
    model_rx(170, 7, 210, 10'h3C7);
    lit(204, 0, 5); lit(206, 0, 4); lit(299, 2, 0); lit(306, 3, 1);

    // Send 0x2C3; s_valid held and s_data changed afterwards are ignored
    a = 320;
    for (int k = a; k < 340; k++) sv_s[k] = 1'b1;
    sd_s[a] = 10'h2C3;
    ack  = a + 1 + 2 * L8;
    fack = ack + SYNC + 2 * L8 + 1 + 12 * L8;
    drive_low(ack, L8);
    drive_low(fack, L8);
    model_tx(a, L8, 10'h2C3, ack, fack);
    lit(321, 2, 0); lit(328, 2, 0); lit(329, 2, 1); lit(340, 0, 11); lit(350, 0, 12);
    lit(356, 2, 0); lit(364, 2, 1); lit(462, 4, 0); lit(463, 4, 1);

    // Collision: rs falls as s_valid rises; send then times out with no ack
    for (int k = 480; k < 621; k++) begin
      sv_s[k] = 1'b1; sd_s[k] = 10'h155;
    end
    drive_low(478, L8);
    drive_word(510, L8, 10'h2AA);
    model_rx(478, L8, 510, 10'h2AA);
    model_timeout(620, L8);
    lit(480, 1, 0); lit(481, 0, 1); lit(620, 3, 1); lit(620, 1, 1); lit(621, 2, 0);
    lit(1140, 0, 10); lit(1141, 5, 1); lit(1141, 0, 0);

    // Reset during TX_BITS
    a = 1160;
    sv_s[a] = 1'b1;
    sd_s[a] = 10'h0F0;
    ack = a + 1 + 2 * L8;
    drive_low(ack, L8);
    model_tx(a, L8, 10'h0F0, ack, -1);
    for (int k = 1210; k < 1214; k++) rst_s[k] = 1'b0;
    for (int k = 1210; k < NCYC; k++) begin
      exp_tx[k] = 1'b1; exp_sd[k] = 1'b0; exp_err[k] = 1'b0;
    end
    lit(1209, 0, 13); lit(1212, 0, 0); lit(1212, 1, 0); lit(1212, 2, 1); lit(1214, 1, 1);
  endtask

  // Per-cycle compare against the expected schedule
  always @(negedge clk) begin
    if (running) begin
      if (!rst_s[cyc]) cur_md = 10'd0;
      if (exp_mv[cyc]) cur_md = exp_md[cyc];
      chk("tx", 32'(tx), 32'(exp_tx[cyc]));
      chk("m_valid", 32'(m_valid), 32'(exp_mv[cyc]));
      chk("send_done", 32'(send_done), 32'(exp_sd[cyc]));
      chk("err", 32'(err), 32'(exp_err[cyc]));
      chk("m_data", 32'(m_data), 32'(cur_md));
      foreach (lits[i]) begin
        if (lits[i].c == cyc) begin
          case (lits[i].sel)
            0: chk("lit_state", 32'(state_out), lits[i].v);
            1: chk("lit_s_ready", 32'(s_ready), lits[i].v);
            2: chk("lit_tx", 32'(tx), lits[i].v);
            3: chk("lit_m_valid", 32'(m_valid), lits[i].v);
            4: chk("lit_send_done", 32'(send_done), lits[i].v);
            default: chk("lit_err", 32'(err), lits[i].v);
          endcase
        end
      end
    end
  end

  initial begin
    build();
    rstn = 1'b0; rx = 1'b1; s_valid = 1'b0; s_data = 10'd0;
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      cyc     = k;
      rstn    = rst_s[k];
      rx      = rx_s[k];
      s_valid = sv_s[k];
      s_data  = sd_s[k];
      running = 1'b1;
    end
    @(negedge clk);
    #1;
    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
